// File: rtl/dds_step_if.sv
// Handshake bundle between the step controller and the phase accumulator.
//   step       : current tuning word
//   step_valid : step holds a value not yet accepted
//   step_ready : accumulator accepts step when step_valid & step_ready
//   sat_pulse  : one-cycle pulse aligned with a clamped step update
interface dds_step_if;
  logic [31:0] step;
  logic        step_valid;
  logic        step_ready;
  logic        sat_pulse;

  modport master (
    output step,
    output step_valid,
    output sat_pulse,
    input  step_ready
  );

  modport slave (
    input  step,
    input  step_valid,
    input  sat_pulse,
    output step_ready
  );
endinterface

// File: rtl/dds_step_controller.sv
// Tuning-word controller for the DDS phase accumulator: synchronizes and
// debounces six adjust keys, arbitrates presses into one signed delta per
// cycle, applies it to the step with saturation and offers the result over a
// valid/ready handshake.
//   clk   : system clock
//   reset : asynchronous active-low reset
//   key_n : raw active-low keys [0] coarse+ [1] coarse- [2] micro+ [3] micro-
//           [4] nano+ [5] nano-
//   bus   : master side of dds_step_if (step, step_valid, step_ready, sat_pulse)
module dds_step_controller #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter logic [31:0] STEP_INIT       = 32'd2147483,
  parameter logic [31:0] STEP_COARSE     = 32'd2147483,
  parameter logic [31:0] STEP_MICRO      = 32'd214748,
  parameter logic [31:0] STEP_NANO       = 32'd214,
  parameter logic [31:0] STEP_MIN        = 32'd214,
  parameter logic [31:0] STEP_MAX        = 32'h7FFF_FFFF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       key_n,
  dds_step_if.master       bus
);

  localparam int unsigned NKEYS = 6;
  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic signed [32:0] D_COARSE = $signed({1'b0, STEP_COARSE});
  localparam logic signed [32:0] D_MICRO  = $signed({1'b0, STEP_MICRO});
  localparam logic signed [32:0] D_NANO   = $signed({1'b0, STEP_NANO});
  localparam logic signed [32:0] S_MIN    = $signed({1'b0, STEP_MIN});
  localparam logic signed [32:0] S_MAX    = $signed({1'b0, STEP_MAX});

  typedef enum logic [1:0] {
    S_OFFER = 2'd0,
    S_IDLE  = 2'd1,
    S_APPLY = 2'd2
  } state_t;

  logic [NKEYS-1:0]            sync1_q, sync2_q;
  logic [NKEYS-1:0]            stable_q, stable_d;
  logic [NKEYS-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [NKEYS-1:0]            ev_q, ev_d;

  state_t             state_q, state_d;
  logic [31:0]        step_q, step_d;
  logic               valid_q, valid_d;
  logic               sat_q, sat_d;
  logic               pend_valid_q, pend_valid_d;
  logic signed [32:0] pend_delta_q, pend_delta_d;

  logic               ev_valid_c;
  logic signed [32:0] ev_delta_c;
  logic signed [32:0] sum_c;

  // Debounce: a level change is accepted after DEBOUNCE_CYCLES mismatching cycles.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    for (int k = 0; k < NKEYS; k++) begin
      if (sync2_q[k] != stable_q[k]) begin
        if (cnt_q[k] == CNT_MAX) begin
          stable_d[k] = sync2_q[k];
        end else begin
          cnt_d[k] = cnt_q[k] + CNT_W'(1);
        end
      end
    end
    // Press event only on a stable 1->0 transition; releases are ignored.
    ev_d = stable_q & ~stable_d;
  end

  // Arbitration: same-class add/sub cancel; coarse > micro > nano.
  always_comb begin
    ev_valid_c = 1'b0;
    ev_delta_c = '0;
    if (ev_q[0] ^ ev_q[1]) begin
      ev_valid_c = 1'b1;
      ev_delta_c = ev_q[0] ? D_COARSE : -D_COARSE;
    end else if (ev_q[2] ^ ev_q[3]) begin
      ev_valid_c = 1'b1;
      ev_delta_c = ev_q[2] ? D_MICRO : -D_MICRO;
    end else if (ev_q[4] ^ ev_q[5]) begin
      ev_valid_c = 1'b1;
      ev_delta_c = ev_q[4] ? D_NANO : -D_NANO;
    end
  end

  assign sum_c = $signed({1'b0, step_q}) + pend_delta_q;

  // Next-state logic: step only changes in APPLY, never while offered.
  always_comb begin
    state_d      = state_q;
    step_d       = step_q;
    sat_d        = 1'b0;
    pend_valid_d = pend_valid_q;
    pend_delta_d = pend_delta_q;

    case (state_q)
      S_OFFER: begin
        if (ev_valid_c) begin
          pend_valid_d = 1'b1;
          pend_delta_d = ev_delta_c;
        end
        if (bus.step_ready) begin
          // An event arriving in the handshake cycle is kept as PEND.
          state_d = (pend_valid_q || ev_valid_c) ? S_APPLY : S_IDLE;
        end
      end
      S_IDLE: begin
        if (ev_valid_c) begin
          pend_valid_d = 1'b1;
          pend_delta_d = ev_delta_c;
          state_d      = S_APPLY;
        end
      end
      S_APPLY: begin
        if (sum_c > S_MAX) begin
          step_d = STEP_MAX;
          sat_d  = 1'b1;
        end else if (sum_c < S_MIN) begin
          step_d = STEP_MIN;
          sat_d  = 1'b1;
        end else begin
          step_d = sum_c[31:0];
        end
        pend_valid_d = ev_valid_c;
        pend_delta_d = ev_valid_c ? ev_delta_c : pend_delta_q;
        state_d      = S_OFFER;
      end
      default: state_d = S_OFFER;
    endcase

    valid_d = (state_d == S_OFFER);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q      <= '1;
      sync2_q      <= '1;
      stable_q     <= '1;
      cnt_q        <= '0;
      ev_q         <= '0;
      state_q      <= S_OFFER;
      step_q       <= STEP_INIT;
      valid_q      <= 1'b1;
      sat_q        <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_delta_q <= '0;
    end else begin
      sync1_q      <= key_n;
      sync2_q      <= sync1_q;
      stable_q     <= stable_d;
      cnt_q        <= cnt_d;
      ev_q         <= ev_d;
      state_q      <= state_d;
      step_q       <= step_d;
      valid_q      <= valid_d;
      sat_q        <= sat_d;
      pend_valid_q <= pend_valid_d;
      pend_delta_q <= pend_delta_d;
    end
  end

  assign bus.step       = step_q;
  assign bus.step_valid = valid_q;
  assign bus.sat_pulse  = sat_q;

endmodule
